// File: rtl/apb_pkg.sv
// Shared APB definitions: bus-phase encoding and default bus widths.
package apb_pkg;

    // Same encoding as the slave-side FSM so both ends read identically in waves.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_t;

    localparam int APB_AW = 8;
    localparam int APB_DW = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request strictly after ptr, wrapping.
module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant_idx,
    output logic          valid
);

    // One extra bit so ptr + offset cannot overflow before the modulo-N fold.
    logic [IW:0] cand;

    // Scan offsets 1..N from the last winner; the first set request wins.
    always_comb begin
        grant_idx = '0;
        valid     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= N; k++) begin
            cand = {1'b0, ptr} + (IW + 1)'(k);
            if (cand >= (IW + 1)'(N)) begin
                cand = cand - (IW + 1)'(N);
            end
            if (!valid && req[cand[IW-1:0]]) begin
                valid     = 1'b1;
                grant_idx = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Multi-requester APB master: round-robin arbitration, one IDLE/SETUP/ACCESS
// transfer at a time, and a wait-state timeout that aborts hung transfers.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int N       = 2,
    parameter int AW      = APB_AW,
    parameter int DW      = APB_DW,
    parameter int TIMEOUT = 16
) (
    input  logic            PCLK,
    input  logic            PRESET,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    req_write,
    input  logic [N*AW-1:0] req_addr,
    input  logic [N*DW-1:0] req_wdata,
    output logic [N-1:0]    done,
    output logic [DW-1:0]   rdata,
    output logic            err,
    output logic            PSEL,
    output logic            PENABLE,
    output logic [AW-1:0]   PADDR,
    output logic            PWRITE,
    output logic [DW-1:0]   PWDATA,
    input  logic [DW-1:0]   PRDATA,
    input  logic            PREADY,
    input  logic            PSLVERR
);

    localparam int IW = $clog2(N);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Counter value during the last ACCESS cycle allowed before the abort.
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    apb_state_t    state;
    logic [IW-1:0] grant;
    logic [IW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic [IW-1:0] arb_idx;
    logic          arb_valid;
    logic          in_access;
    logic          timeout_hit;
    logic          finish;

    rr_arbiter #(.N(N)) u_rr (
        .req       (req),
        .ptr       (ptr),
        .grant_idx (arb_idx),
        .valid     (arb_valid)
    );

    // Completion fires on PREADY or when the wait-state budget is exhausted;
    // a reset in the same cycle suppresses the strobe.
    always_comb begin
        in_access   = (state == ACCESS) && !PRESET;
        timeout_hit = in_access && (TIMEOUT != 0) && !PREADY && (cnt == CNT_LAST);
        finish      = (in_access && PREADY) || timeout_hit;
        done        = '0;
        rdata       = '0;
        err         = 1'b0;
        if (finish) begin
            done[grant] = 1'b1;
            err         = timeout_hit ? 1'b1 : PSLVERR;
            if (!timeout_hit && !PWRITE) begin
                rdata = PRDATA;
            end
        end
    end

    // Bus sequencer: arbitrate in IDLE, one SETUP cycle, then ACCESS until done.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= IDLE;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
            grant   <= '0;
            ptr     <= IW'(N - 1);
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    if (arb_valid) begin
                        grant  <= arb_idx;
                        ptr    <= arb_idx;
                        PADDR  <= req_addr[arb_idx*AW +: AW];
                        PWRITE <= req_write[arb_idx];
                        PWDATA <= req_wdata[arb_idx*DW +: DW];
                        PSEL   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (finish) begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        cnt     <= '0;
                        state   <= IDLE;
                    end else if (!PREADY && cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    cnt     <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Multi-requester APB master. Arbitrates N internal requesters round-robin and sequences one APB transfer at a time onto a shared APB bus that drives an APB slave, such as the GPIO block.
- Generates PSEL/PENABLE per the APB IDLE/SETUP/ACCESS protocol and waits on PREADY.
- A wait-state timeout terminates hung transfers with an error.

Parameters:
- N, 2, number of requesters (>=2)
- AW, 8, address width
- DW, 32, data width
- TIMEOUT, 16, maximum ACCESS cycles before forced abort; 0 disables the timeout

Ports:
- PCLK  in  1  clock
- PRESET  in  1  synchronous active-high reset
- req  in  N  per-requester transfer request; held until done
- req_write  in  N  per-requester direction (1 = write)
- req_addr  in  N*AW  per-requester address, packed with requester i at [i*AW +: AW]
- req_wdata  in  N*DW  per-requester write data, packed with requester i at [i*DW +: DW]
- done  out  N  one-hot completion strobe, combinational
- rdata  out  DW  read data, valid only while done != 0
- err  out  1  error flag, valid only while done != 0
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PADDR  out  AW  APB address
- PWRITE  out  1  APB direction
- PWDATA  out  DW  APB write data
- PRDATA  in  DW  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

Behaviour:
- Clocking and reset: single clock PCLK. PRESET is synchronous and active-high.
- Reset values (at the first PCLK edge with PRESET=1):
  - state = IDLE
  - PSEL = PENABLE = PWRITE = 0; PADDR = 0; PWDATA = 0
  - grant index = 0
  - rr pointer (last granted) = N-1, so requester 0 wins the first arbitration
  - timeout counter = 0
- done/rdata/err are combinational and are 0 whenever state != ACCESS.
- IDLE state:
  - PSEL = 0, PENABLE = 0.
  - If any req is high, pick the winner round-robin: the first set bit searching from pointer+1 upward, wrapping modulo N.
  - Register the winner's grant index, PADDR, PWRITE and PWDATA; update pointer = winner; go to SETUP.
- SETUP state: exactly one cycle, PSEL = 1, PENABLE = 0; go to ACCESS unconditionally.
- ACCESS state:
  - PSEL = 1, PENABLE = 1. PADDR, PWRITE and PWDATA are held stable.
  - The counter increments on each ACCESS cycle with PREADY = 0.
  - Completion when PREADY = 1:
    - done[grant] = 1 that cycle.
    - err = PSLVERR.
    - rdata = PRDATA if the transfer is a read, else 0.
    - Next state IDLE; counter cleared.
  - Timeout when TIMEOUT != 0, PREADY = 0 and the counter has reached TIMEOUT-1 (i.e. the TIMEOUT-th ACCESS cycle):
    - done[grant] = 1, err = 1, rdata = 0.
    - Next state IDLE; counter cleared.
- Latency and throughput:
  - A PREADY-immediate transfer takes 2 bus cycles (SETUP + ACCESS) from the first PSEL.
  - Req-to-done is 3 cycles (IDLE arbitration + SETUP + ACCESS).
  - Minimum issue interval is 3 cycles. There is always one IDLE cycle between transfers, and PSEL deasserts in it.
- Requester contract:
  - Hold req, req_write, req_addr and req_wdata stable from assertion until the edge at which done[i] is sampled high.
  - Deassert req on that same edge.
  - Requests changed earlier are a protocol violation; behaviour is unspecified, but the block must never hang.
- Simultaneous events:
  - Req changes while the FSM is in SETUP or ACCESS have no effect until the next IDLE.
  - All requesters high: grants rotate 0,1,…,N-1,0.
- The timeout counter width is $clog2(TIMEOUT+1), minimum 1 bit. It saturates and never wraps.
- Reset mid-transfer: the FSM returns to IDLE on the next edge and PSEL/PENABLE drop. No done is issued, and the aborted requester's req is rearbitrated after reset releases.
- PENABLE is never 1 while PSEL is 0. PSEL is never high for more than 1+TIMEOUT consecutive cycles when the timeout is enabled.

Decomposition:
- Shared package apb_pkg holds:
  - typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t, with encodings 00/01/10 matching the slave-side FSM
  - APB_AW/APB_DW default constants
- One sub-module: rr_arbiter, parameterised by N.
  - Inputs: req and the pointer.
  - Output: one-hot/indexed winner plus a valid flag.
  - Purely combinational; the pointer register lives in apb_master_arbiter.

Test Plan:
1. Single write: req[0]=1, write, addr 0x04, wdata 0xA5A5_0001, PREADY tied 1 -> PSEL rises the cycle after req; PENABLE one cycle later with PADDR=0x04 and PWDATA=0xA5A5_0001; done=2'b01 and err=0 in that ACCESS cycle; PSEL=0 the next cycle.
2. Read with wait states: req[1] read of addr 0x08; PREADY low for 3 ACCESS cycles, then high with PRDATA=0x0000_00FF -> PENABLE high for 4 cycles; done=2'b10 and rdata=0xFF on the 4th.
3. Round-robin: req=2'b11 held, each requester re-asserting after its done -> grant sequence 0,1,0,1, with one IDLE cycle between transfers.
4. Timeout: TIMEOUT=16, PREADY stuck 0 -> exactly 16 ACCESS cycles, then done with err=1 and rdata=0; FSM returns to IDLE; a following transfer completes normally.
5. Slave error: PREADY=1 with PSLVERR=1 on a write -> done with err=1; next arbitration is unaffected.
6. Reset mid-ACCESS: assert PRESET for 1 cycle during a wait state -> PSEL=PENABLE=0 on the next edge, no done pulse; after release, the still-high req[0] is rearbitrated and completes.
